// File: rtl/mips_pkg.sv
// Shared definitions for the register-file writeback path.
//   DATA_W_DEF / ADDR_W_DEF : default data and register-address widths
//   REG_ZERO                : architectural $zero, never written
//   req_e                   : requester index encoding (p0 = ALU, p1 = load unit)
package mips_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int REG_ZERO   = 0;

  typedef enum logic {
    REQ_P0 = 1'b0,
    REQ_P1 = 1'b1
  } req_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter with its priority pointer.
//   clk, rst_n : clock, async active-low reset (pointer returns to p0)
//   en         : arbitration allowed this cycle
//   req0/req1  : requests from p0/p1
//   gnt0/gnt1  : one-hot (or zero) grants
// After any grant the pointer favours the side that did not win.
module rr_arbiter2
  import mips_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  req_e ptr_q;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block can leave it unassigned and infer a latch.
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (en) begin
      gnt0 = req0 & (~req1 | (ptr_q == REQ_P0));
      gnt1 = req1 & (~req0 | (ptr_q == REQ_P1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= REQ_P0;
    end else if (gnt0) begin
      // NOTE: state registers use non-blocking assignment so every flop
      // samples pre-edge values regardless of statement order.
      ptr_q <= REQ_P1;
    end else if (gnt1) begin
      ptr_q <= REQ_P0;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file's single write port between p0 (ALU) and p1
// (load unit) through a one-entry write stage, and bypasses the staged
// value onto both asynchronous read ports.
//   p0_*/p1_*        : valid/ready write requests (addr, data)
//   rf_hold          : freezes the write port; stage holds its contents
//   rf_we/waddr/wdata: to register file we3/A3/WD3
//   rd_addr1/2       : read addresses, rf_rd1/2 raw read data
//   rd_data1/2       : read data with the staged write forwarded
//   conflict_cnt     : saturating count of cycles with both requests valid
module regfile_write_arbiter
  import mips_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_valid,
  output logic              p0_ready,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_data,
  input  logic              p1_valid,
  output logic              p1_ready,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_data,
  input  logic              rf_hold,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  input  logic [DATA_W-1:0] rf_rd1,
  input  logic [DATA_W-1:0] rf_rd2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic [CNT_W-1:0]  conflict_cnt
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  logic              stage_valid;
  logic [ADDR_W-1:0] stage_addr;
  logic [DATA_W-1:0] stage_data;
  logic [CNT_W-1:0]  cnt_q;

  logic              accept_ok;
  logic              drain;
  logic              gnt0;
  logic              gnt1;
  logic              load;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_data;

  // A draining stage frees its slot on the same edge, so it can be refilled.
  assign drain     = stage_valid & ~rf_hold;
  assign accept_ok = ~stage_valid | ~rf_hold;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (accept_ok),
    .req0  (p0_valid),
    .req1  (p1_valid),
    .gnt0  (gnt0),
    .gnt1  (gnt1)
  );

  assign p0_ready = gnt0;
  assign p1_ready = gnt1;

  always_comb begin
    g_addr = p0_addr;
    g_data = p0_data;
    if (gnt1) begin
      g_addr = p1_addr;
      g_data = p1_data;
    end
  end

  // Grants to $zero are acknowledged but never staged.
  assign load = (gnt0 | gnt1) & (g_addr != ZERO_ADDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the stage payload is reset too (not only the valid bit) because
      // it is visible on rf_waddr/rf_wdata; this is one register, not an array.
      stage_valid <= 1'b0;
      stage_addr  <= '0;
      stage_data  <= '0;
    end else if (load) begin
      stage_valid <= 1'b1;
      stage_addr  <= g_addr;
      stage_data  <= g_data;
    end else if (drain) begin
      stage_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (p0_valid & p1_valid & (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign conflict_cnt = cnt_q;

  assign rf_we    = stage_valid & ~rf_hold;
  assign rf_waddr = stage_addr;
  assign rf_wdata = stage_data;

  // Forward the staged write so readers never see the stale register value,
  // including while the port is frozen.
  function automatic logic [DATA_W-1:0] bypass(input logic [ADDR_W-1:0] ra,
                                               input logic [DATA_W-1:0] raw);
    if (ra == ZERO_ADDR)                          return '0;
    else if (stage_valid && (stage_addr == ra))   return stage_data;
    else                                          return raw;
  endfunction

  assign rd_data1 = bypass(rd_addr1, rf_rd1);
  assign rd_data2 = bypass(rd_addr2, rf_rd2);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          p0_valid, p1_valid, p0_ready, p1_ready;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [DW-1:0] p0_data, p1_data;
  logic          rf_hold;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [AW-1:0] rd_addr1, rd_addr2;
  logic [DW-1:0] rf_rd1, rf_rd2, rd_data1, rd_data2;
  logic [CW-1:0] conflict_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;
  wr_t exp_q[$];

  // Register file model. Entry 0 holds junk so that zero forcing in the
  // read bypass is observable.
  logic [DW-1:0] rf_mem [32];
  initial begin
    for (int i = 0; i < 32; i++) rf_mem[i] = '0;
    rf_mem[0] = 32'hFFFF_FFFF;
  end
  always @(posedge clk) if (rf_we) rf_mem[rf_waddr] <= rf_wdata;
  assign rf_rd1 = rf_mem[rd_addr1];
  assign rf_rd2 = rf_mem[rd_addr2];

  always #5 clk = ~clk;

  regfile_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_addr(p0_addr), .p0_data(p0_data),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_addr(p1_addr), .p1_data(p1_data),
    .rf_hold(rf_hold), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .rd_data1(rd_data1), .rd_data2(rd_data2), .conflict_cnt(conflict_cnt)
  );

  // Scoreboard: every register-file write must match the oldest expected one.
  always @(negedge clk) begin
    if (rst_n && rf_we) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got addr=%0d data=%h, expected no write",
                 rf_waddr, rf_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (rf_waddr !== e.addr || rf_wdata !== e.data) begin
          n_fail++;
          $display("FAIL write_order: got addr=%0d data=%h, expected addr=%0d data=%h",
                   rf_waddr, rf_wdata, e.addr, e.data);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic idle_inputs();
    p0_valid = 1'b0; p1_valid = 1'b0;
    p0_addr = '0; p1_addr = '0; p0_data = '0; p1_data = '0;
    rf_hold = 1'b0; rd_addr1 = '0; rd_addr2 = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    exp_q.delete();
    step();
    step();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #3;
    n_checks++;
    if (rf_we !== 1'b0 || rf_waddr !== '0 || rf_wdata !== '0) begin
      n_fail++;
      $display("FAIL reset_port: got we=%b addr=%0d data=%h, expected 0/0/0",
               rf_we, rf_waddr, rf_wdata);
    end
    n_checks++;
    if (conflict_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_cnt: got %0d, expected 0", conflict_cnt);
    end
    step();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset_midwrite();
    // Stage addr 7 while the port is frozen, so it cannot drain.
    rf_hold = 1'b1;
    p0_valid = 1'b1; p0_addr = 5'd7; p0_data = 32'hA5A5_A5A5;
    #1;
    n_checks++;
    if (p0_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_empty_accept: got p0_ready=%b, expected 1", p0_ready);
    end
    step();
    p0_valid = 1'b0;
    rd_addr1 = 5'd7;
    #1;
    n_checks++;
    if (rf_we !== 1'b0 || rd_data1 !== 32'hA5A5_A5A5) begin
      n_fail++;
      $display("FAIL staged_hold: got we=%b rd1=%h, expected we=0 rd1=a5a5a5a5",
               rf_we, rd_data1);
    end
    // Both requesting while stuck: counts a conflict, pointer unaffected.
    p0_valid = 1'b1; p1_valid = 1'b1; p0_addr = 5'd9; p1_addr = 5'd8;
    step();
    p0_valid = 1'b0; p1_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (rf_we !== 1'b0 || conflict_cnt !== '0 || rd_data1 !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid: got we=%b cnt=%0d rd1=%h, expected 0/0/0",
               rf_we, conflict_cnt, rd_data1);
    end
    rf_hold = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (rf_mem[7] !== 32'h0) begin
      n_fail++;
      $display("FAIL discarded_write: got reg7=%h, expected 0", rf_mem[7]);
    end
    // Pointer back at p0: p0 wins the first tie.
    p0_valid = 1'b1; p0_addr = 5'd1; p0_data = 32'h0000_0011;
    p1_valid = 1'b1; p1_addr = 5'd2; p1_data = 32'h0000_0022;
    #1;
    n_checks++;
    if (p0_ready !== 1'b1 || p1_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ptr_after_reset: got ready p0=%b p1=%b, expected 1/0",
               p0_ready, p1_ready);
    end
    push(5'd1, 32'h0000_0011);
    step();
    p0_valid = 1'b0;
    #1;
    n_checks++;
    if (p1_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL loser_served: got p1_ready=%b, expected 1", p1_ready);
    end
    push(5'd2, 32'h0000_0022);
    step();
    p1_valid = 1'b0;
    step();
    step();
  endtask

  task automatic test_single();
    p0_valid = 1'b1; p0_addr = 5'd10; p0_data = 32'h1111_1111;
    #1;
    n_checks++;
    if (p0_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL single_ready: got %b, expected 1", p0_ready);
    end
    push(5'd10, 32'h1111_1111);
    step();
    p0_valid = 1'b0;
    rd_addr1 = 5'd10;
    #1;
    n_checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd10 || rd_data1 !== 32'h1111_1111) begin
      n_fail++;
      $display("FAIL single_stage: got we=%b addr=%0d rd1=%h, expected 1/10/11111111",
               rf_we, rf_waddr, rd_data1);
    end
    step();
    n_checks++;
    if (rf_mem[10] !== 32'h1111_1111 || rd_data1 !== 32'h1111_1111 || rf_we !== 1'b0) begin
      n_fail++;
      $display("FAIL single_commit: got reg10=%h rd1=%h we=%b, expected 11111111/11111111/0",
               rf_mem[10], rd_data1, rf_we);
    end
    rd_addr1 = '0;
  endtask

  task automatic test_contention();
    int w;
    int n0 = 0;
    int n1 = 0;
    do_reset();
    p0_valid = 1'b1; p0_addr = 5'd3; p0_data = 32'h3000_0000;
    p1_valid = 1'b1; p1_addr = 5'd4; p1_data = 32'h4000_0000;
    for (int k = 0; k < 4; k++) begin
      w = k % 2;
      #1;
      n_checks++;
      if (p0_ready !== (w == 0) || p1_ready !== (w == 1)) begin
        n_fail++;
        $display("FAIL contention_grant[%0d]: got ready p0=%b p1=%b, expected winner p%0d",
                 k, p0_ready, p1_ready, w);
      end
      if (w == 0) push(5'd3, p0_data);
      else        push(5'd4, p1_data);
      step();
      if (w == 0) begin n0++; p0_data = 32'h3000_0000 + n0; end
      else        begin n1++; p1_data = 32'h4000_0000 + n1; end
    end
    p0_valid = 1'b0; p1_valid = 1'b0;
    #1;
    n_checks++;
    if (conflict_cnt !== 4'd4) begin
      n_fail++;
      $display("FAIL contention_cnt: got %0d, expected 4", conflict_cnt);
    end
    step();
    step();
  endtask

  task automatic test_zero_reg();
    // p0 fills the stage, then a $zero write lands while it drains.
    p0_valid = 1'b1; p0_addr = 5'd5; p0_data = 32'h0505_0505;
    push(5'd5, 32'h0505_0505);
    step();
    p0_valid = 1'b0;
    p1_valid = 1'b1; p1_addr = 5'd0; p1_data = 32'hDEAD_BEEF;
    #1;
    n_checks++;
    if (p1_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_ready: got %b, expected 1", p1_ready);
    end
    step();
    p1_valid = 1'b0;
    rd_addr1 = 5'd0;
    #1;
    n_checks++;
    if (rf_we !== 1'b0 || rd_data1 !== 32'h0) begin
      n_fail++;
      $display("FAIL zero_drop: got we=%b rd1=%h, expected 0/0", rf_we, rd_data1);
    end
    step();
  endtask

  task automatic test_hold();
    p0_valid = 1'b1; p0_addr = 5'd20; p0_data = 32'h1802_2002;
    push(5'd20, 32'h1802_2002);
    step();
    rf_hold = 1'b1;
    p0_addr = 5'd21; p0_data = 32'h2121_2121;
    rd_addr2 = 5'd20;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++;
      if (rf_we !== 1'b0 || p0_ready !== 1'b0 || rd_data2 !== 32'h1802_2002) begin
        n_fail++;
        $display("FAIL hold[%0d]: got we=%b p0_ready=%b rd2=%h, expected 0/0/18022002",
                 k, rf_we, p0_ready, rd_data2);
      end
      step();
    end
    rf_hold = 1'b0;
    #1;
    n_checks++;
    if (rf_we !== 1'b1 || p0_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_release: got we=%b p0_ready=%b, expected 1/1", rf_we, p0_ready);
    end
    push(5'd21, 32'h2121_2121);
    step();
    p0_valid = 1'b0;
    step();
    n_checks++;
    if (rf_mem[20] !== 32'h1802_2002 || rf_mem[21] !== 32'h2121_2121) begin
      n_fail++;
      $display("FAIL hold_commit: got reg20=%h reg21=%h, expected 18022002/21212121",
               rf_mem[20], rf_mem[21]);
    end
    rd_addr2 = '0;
  endtask

  task automatic test_saturation();
    int exp_cnt;
    do_reset();
    // Both target $zero so the stage never fills; only the counter moves.
    p0_valid = 1'b1; p1_valid = 1'b1; p0_addr = '0; p1_addr = '0;
    for (int k = 0; k < (2 ** CW) + 5; k++) begin
      step();
      exp_cnt = (k + 1 > (2 ** CW) - 1) ? (2 ** CW) - 1 : k + 1;
      n_checks++;
      if (conflict_cnt !== CW'(exp_cnt)) begin
        n_fail++;
        $display("FAIL sat_cnt[%0d]: got %0d, expected %0d", k, conflict_cnt, exp_cnt);
      end
    end
    p0_valid = 1'b0; p1_valid = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_reset_midwrite();
    test_single();
    test_contention();
    test_zero_reg();
    test_hold();
    test_saturation();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_writes: got %0d pending, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
